// File: rtl/pipe_share_arbiter.sv
// Round-robin front end for one shared fixed-latency element unit.
// Each issued operation carries its requester tag down a shift pipeline, so the result returns to its issuer.
module pipe_share_arbiter #(
   parameter int element_width = 64,
   parameter int NUM_REQ       = 4,
   parameter int LATENCY       = 4,
   parameter int ID_W          = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ*element_width-1:0] op_a,
   input  logic [NUM_REQ*element_width-1:0] op_b,
   input  logic                             hold,
   output logic [NUM_REQ-1:0]               grant,
   output logic                             unit_valid,
   output logic [element_width-1:0]         unit_a,
   output logic [element_width-1:0]         unit_b,
   input  logic [element_width-1:0]         unit_result,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [element_width-1:0]         rsp_data,
   output logic [3:0]                       in_flight,
   output logic                             idle
);

   // Returns {found, index} of the first set request, scanning upward from ptr with wrap.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] rq,
                                             input logic [ID_W-1:0]    ptr);
      logic            found;
      logic [ID_W-1:0] idx;
      logic [ID_W-1:0] cand;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && rq[cand]) begin
            found = 1'b1;
            idx   = cand;
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   logic [ID_W-1:0]          r_ptr;
   logic                     r_unit_valid;
   logic [element_width-1:0] r_unit_a;
   logic [element_width-1:0] r_unit_b;
   logic [LATENCY:0]         r_tag_v;
   logic [ID_W-1:0]          r_tag_id [0:LATENCY];
   logic [3:0]               r_in_flight;

   logic [ID_W:0]            w_pick;
   logic                     w_issue;
   logic [ID_W-1:0]          w_idx;
   logic [ID_W-1:0]          w_ptr_next;
   logic [NUM_REQ-1:0]       w_grant;
   logic                     w_retire;
   logic [NUM_REQ-1:0]       w_rsp_valid;

   // Arbitration: grant is suppressed while held or in reset.
   always_comb begin
      w_pick  = rr_pick(req, r_ptr);
      w_idx   = w_pick[ID_W-1:0];
      w_issue = w_pick[ID_W] & ~hold & ~rst;
      if (w_issue) begin
         w_grant = NUM_REQ'(1) << w_idx;
      end else begin
         w_grant = '0;
      end
      if (int'(w_idx) == NUM_REQ - 1) begin
         w_ptr_next = '0;
      end else begin
         w_ptr_next = w_idx + ID_W'(1);
      end
   end

   // Round-robin pointer advances past the most recent winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_issue) begin
         r_ptr <= w_ptr_next;
      end else begin
         r_ptr <= r_ptr;
      end
   end

   // Operand registers feeding the shared unit; operands hold when idle to avoid needless toggling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_unit_valid <= 1'b0;
         r_unit_a     <= '0;
         r_unit_b     <= '0;
      end else if (w_issue) begin
         r_unit_valid <= 1'b1;
         r_unit_a     <= op_a[w_idx*element_width +: element_width];
         r_unit_b     <= op_b[w_idx*element_width +: element_width];
      end else begin
         r_unit_valid <= 1'b0;
         r_unit_a     <= r_unit_a;
         r_unit_b     <= r_unit_b;
      end
   end

   // Tag pipeline: stage 0 is loaded with the issue, the tail lines up with unit_result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_v <= '0;
         for (int k = 0; k <= LATENCY; k++) begin
            r_tag_id[k] <= '0;
         end
      end else begin
         r_tag_v     <= {r_tag_v[LATENCY-1:0], w_issue};
         r_tag_id[0] <= w_idx;
         for (int k = 1; k <= LATENCY; k++) begin
            r_tag_id[k] <= r_tag_id[k-1];
         end
      end
   end

   // Result strobe decode of the tail tag.
   always_comb begin
      w_retire = r_tag_v[LATENCY];
      if (w_retire) begin
         w_rsp_valid = NUM_REQ'(1) << r_tag_id[LATENCY];
      end else begin
         w_rsp_valid = '0;
      end
   end

   // Outstanding-operation counter; simultaneous issue and retire cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_flight <= 4'd0;
      end else begin
         case ({w_issue, w_retire})
            2'b10: begin
               if (r_in_flight != 4'hF) begin
                  r_in_flight <= r_in_flight + 4'd1;
               end else begin
                  r_in_flight <= r_in_flight;
               end
            end
            2'b01: begin
               if (r_in_flight != 4'd0) begin
                  r_in_flight <= r_in_flight - 4'd1;
               end else begin
                  r_in_flight <= r_in_flight;
               end
            end
            default: r_in_flight <= r_in_flight;
         endcase
      end
   end

   assign grant      = w_grant;
   assign unit_valid = r_unit_valid;
   assign unit_a     = r_unit_a;
   assign unit_b     = r_unit_b;
   assign rsp_valid  = w_rsp_valid;
   assign rsp_data   = unit_result;
   assign in_flight  = r_in_flight;
   assign idle       = (r_in_flight == 4'd0);

   pipe_share_arbiter_chk #(
      .NUM_REQ (NUM_REQ),
      .LATENCY (LATENCY)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .grant     (w_grant),
      .rsp_valid (w_rsp_valid),
      .in_flight (r_in_flight)
   );

endmodule

// Property checks on grant/response encoding and the outstanding-count bound.
module pipe_share_arbiter_chk #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 4
) (
   input logic               clk,
   input logic               rst,
   input logic               hold,
   input logic [NUM_REQ-1:0] grant,
   input logic [NUM_REQ-1:0] rsp_valid,
   input logic [3:0]         in_flight
);

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_rsp_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
   a_hold_quiet:   assert property (@(posedge clk) disable iff (rst) hold |-> (grant == '0));
   a_flight_max:   assert property (@(posedge clk) disable iff (rst) in_flight <= 4'(LATENCY + 1));

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter; the shared unit is modelled as a 4-deep adder pipeline with no reset.
module tb_pipe_share_arbiter;

   logic         clk;
   logic         rst;
   logic [3:0]   req;
   logic [255:0] op_a;
   logic [255:0] op_b;
   logic         hold;
   logic [3:0]   grant;
   logic         unit_valid;
   logic [63:0]  unit_a;
   logic [63:0]  unit_b;
   logic [63:0]  unit_result;
   logic [3:0]   rsp_valid;
   logic [63:0]  rsp_data;
   logic [3:0]   in_flight;
   logic         idle;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] m_pipe [0:3];
   logic [63:0] exp_sum [0:3];
   int          exp_flight [0:9];
   logic [3:0]  one4;

   pipe_share_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .op_a        (op_a),
      .op_b        (op_b),
      .hold        (hold),
      .grant       (grant),
      .unit_valid  (unit_valid),
      .unit_a      (unit_a),
      .unit_b      (unit_b),
      .unit_result (unit_result),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .in_flight   (in_flight),
      .idle        (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      m_pipe[0] <= unit_a + unit_b;
      for (int k = 1; k < 4; k++) m_pipe[k] <= m_pipe[k-1];
   end
   assign unit_result = m_pipe[3];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         next_cyc();
         #2;
         k++;
      end while (!idle && k < 20);
      check_val("drain_idle", 64'(idle), 64'(1'b1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      one4 = 4'b0001;
      exp_sum[0] = 64'd110; exp_sum[1] = 64'd211; exp_sum[2] = 64'd312; exp_sum[3] = 64'd413;
      exp_flight[0] = 0; exp_flight[1] = 1; exp_flight[2] = 2; exp_flight[3] = 3; exp_flight[4] = 4;
      exp_flight[5] = 4; exp_flight[6] = 3; exp_flight[7] = 2; exp_flight[8] = 1; exp_flight[9] = 0;

      // reset state, including grant forced low with requests pending
      rst = 1'b1; req = 4'b1111; hold = 1'b0; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      #3;
      check_val("rst_grant", 64'(grant), 64'(4'b0000));
      check_val("rst_uvalid", 64'(unit_valid), 64'(1'b0));
      check_val("rst_unit_a", unit_a, 64'd0);
      check_val("rst_flight", 64'(in_flight), 64'd0);
      check_val("rst_idle", 64'(idle), 64'(1'b1));
      check_val("rst_rsp", 64'(rsp_valid), 64'(4'b0000));

      // single op
      @(posedge clk); #1;
      rst = 1'b0; req = 4'b0001; op_a = 256'd3; op_b = 256'd5; #2;
      check_val("single_grant", 64'(grant), 64'(4'b0001));
      for (int c = 1; c <= 6; c++) begin
         next_cyc(); req = 4'b0000; #2;
         if (c == 1) begin
            check_val("single_uvalid", 64'(unit_valid), 64'(1'b1));
            check_val("single_a", unit_a, 64'd3);
            check_val("single_b", unit_b, 64'd5);
         end
         check_val("single_flight", 64'(in_flight), (c <= 5) ? 64'd1 : 64'd0);
         check_val("single_rsp", 64'(rsp_valid), (c == 5) ? 64'(4'b0001) : 64'(4'b0000));
         if (c == 5) check_val("single_data", rsp_data, 64'd8);
      end

      // all four at once from pointer 0
      next_cyc(); rst = 1'b1;
      next_cyc(); rst = 1'b0;
      op_a = {64'd13, 64'd12, 64'd11, 64'd10};
      op_b = {64'd400, 64'd300, 64'd200, 64'd100};
      for (int c = 0; c <= 9; c++) begin
         if (c > 0) next_cyc();
         req = (c < 4) ? (4'b1111 << c) : 4'b0000;
         #2;
         check_val("all4_grant", 64'(grant), (c < 4) ? 64'(one4 << c) : 64'd0);
         check_val("all4_flight", 64'(in_flight), 64'(exp_flight[c]));
         if (c >= 1 && c <= 4) check_val("all4_unit_a", unit_a, 64'(9 + c));
         if (c >= 5 && c <= 8) begin
            check_val("all4_rsp", 64'(rsp_valid), 64'(one4 << (c - 5)));
            check_val("all4_data", rsp_data, exp_sum[c-5]);
         end else begin
            check_val("all4_norsp", 64'(rsp_valid), 64'd0);
         end
      end

      // fairness after a grant to requester 2
      next_cyc(); req = 4'b0100; #2;
      check_val("fair_g2", 64'(grant), 64'(4'b0100));
      next_cyc(); req = 4'b1001; #2;
      check_val("fair_g3", 64'(grant), 64'(4'b1000));
      next_cyc(); req = 4'b0001; #2;
      check_val("fair_g0", 64'(grant), 64'(4'b0001));
      next_cyc(); req = 4'b0000;
      wait_idle();

      // requester 1 alone, back to back; in_flight saturates at LATENCY+1
      for (int i = 0; i < 8; i++) begin
         next_cyc(); req = 4'b0010; #2;
         check_val("b2b_grant", 64'(grant), 64'(4'b0010));
         check_val("b2b_flight", 64'(in_flight), (i < 5) ? 64'(i) : 64'd5);
      end
      next_cyc(); req = 4'b0000;
      wait_idle();

      // hold: pointer is 2 here
      next_cyc(); req = 4'b1111; hold = 1'b0; #2;
      check_val("hold_pre", 64'(grant), 64'(4'b0100));
      for (int c = 1; c <= 5; c++) begin
         next_cyc(); req = 4'b1011; hold = 1'b1; #2;
         check_val("hold_grant", 64'(grant), 64'd0);
         if (c == 5) begin
            check_val("hold_rsp", 64'(rsp_valid), 64'(4'b0100));
            check_val("hold_flight", 64'(in_flight), 64'd1);
         end
      end
      next_cyc(); hold = 1'b0; #2;
      check_val("hold_resume", 64'(grant), 64'(4'b1000));
      check_val("hold_idle", 64'(idle), 64'(1'b1));
      next_cyc(); req = 4'b0011; #2;
      check_val("hold_next", 64'(grant), 64'(4'b0001));
      next_cyc(); req = 4'b0000;
      wait_idle();

      // reset in the middle of three issues; pointer is 1 here
      next_cyc(); req = 4'b0111; #2;
      check_val("mid_g1", 64'(grant), 64'(4'b0010));
      next_cyc(); req = 4'b0101; #2;
      check_val("mid_g2", 64'(grant), 64'(4'b0100));
      next_cyc(); req = 4'b0001; #2;
      check_val("mid_g0", 64'(grant), 64'(4'b0001));
      rst = 1'b1; #1;
      check_val("mid_flight", 64'(in_flight), 64'd0);
      check_val("mid_idle", 64'(idle), 64'(1'b1));
      check_val("mid_uvalid", 64'(unit_valid), 64'(1'b0));
      check_val("mid_grant", 64'(grant), 64'd0);
      next_cyc(); rst = 1'b0; req = 4'b0000;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) next_cyc();
         #2;
         check_val("mid_norsp", 64'(rsp_valid), 64'd0);
      end
      next_cyc(); req = 4'b1010; #2;
      check_val("post_rst_grant", 64'(grant), 64'(4'b0010));
      next_cyc(); req = 4'b0000;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
